arith_seq: RTL

ARITH_SEQ -- requirements
Module: arith_seq

---
 rtl/arith_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/arith_seq.sv
// Command sequencer driving an external arithmetic unit and returning its result.
// Optional result self-check enabled by defining ARITH_SEQ_CHECK_EN.
module arith_seq #(
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_op,
   output logic        cmd_ready,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   output logic [15:0] au_data_1,
   output logic [15:0] au_data_2,
   output logic [1:0]  au_op_sel,
   input  logic [15:0] au_data_out,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   input  logic        rsp_ready,
   output logic        busy,
   output logic [15:0] op_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] res_q, res_d;
   logic        vld_q, vld_d;
   logic [15:0] ops_q, ops_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      vld_d   = vld_q;
      ops_d   = ops_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               a_d     = cmd_a;
               b_d     = cmd_b;
               op_d    = cmd_op;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               res_d   = au_data_out;
               vld_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            // Handshake cycle returns to IDLE only; acceptance waits a cycle
            if (rsp_ready) begin
               vld_d   = 1'b0;
               ops_d   = ops_q + 16'd1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         vld_q   <= 1'b0;
         ops_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         vld_q   <= vld_d;
         ops_q   <= ops_d;
      end
   end

`ifdef ARITH_SEQ_CHECK_EN
   logic [15:0] ref_res;
   logic        err_q;

   always_comb begin
      ref_res = '0;
      unique case (op_q)
         2'b00: ref_res = a_q + b_q;
         2'b01: ref_res = a_q - b_q;
         2'b10: ref_res = a_q * b_q;
         2'b11: ref_res = a_q & b_q;
         default: ref_res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (state_q == S_WAIT && cnt_q == 4'd0) begin
         err_q <= (ref_res != au_data_out);
      end
   end

   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign au_data_1 = a_q;
   assign au_data_2 = b_q;
   assign au_op_sel = op_q;
   assign rsp_valid = vld_q;
   assign rsp_data  = res_q;
   assign op_count  = ops_q;

endmodule
